// File: rtl/tdp_bram_pkg.sv
// tdp_bram_pkg: shared read-mode, priority and clear-FSM encodings for tdp_bram_ctrl
package tdp_bram_pkg;
   localparam int RD_FIRST  = 0;
   localparam int WR_FIRST  = 1;
   localparam int NO_CHANGE = 2;
   localparam int PRIO_A    = 0;
   localparam int PRIO_B    = 1;
   typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/tdp_bram_init_fsm.sv
// tdp_bram_init_fsm: post-reset sweep that zeroes one word per cycle, then parks in READY
module tdp_bram_init_fsm
   import tdp_bram_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1 << ADDR_W
)
(
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);
   state_t state;
   logic [ADDR_W-1:0] ptr;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= CLEAR;
         ptr       <= '0;
         init_busy <= 1'b1;
      end else if (state == CLEAR) begin
         ptr <= ptr + 1'b1;
         if (ptr == ADDR_W'(DEPTH - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
         end
      end
   assign clr_we   = init_busy;
   assign clr_addr = ptr;
endmodule

// File: rtl/tdp_bram_ctrl.sv
// tdp_bram_ctrl: true dual-port RAM with byte enables, RD_MODE read-during-write and post-reset clear.
// Define TDP_BRAM_OUTREG_EN for an extra output register stage (2-cycle read latency).
module tdp_bram_ctrl
   import tdp_bram_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 10,
   parameter int DEPTH    = 1 << ADDR_W,
   parameter int RD_MODE  = RD_FIRST,
   parameter int PRIORITY = PRIO_A
)
(
   input  logic                clk,
   input  logic                rst,
   output logic                init_busy,
   input  logic                wrena,
   input  logic                rdena,
   input  logic [ADDR_W-1:0]   addra,
   input  logic [DATA_W/8-1:0] bea,
   input  logic [DATA_W-1:0]   dina,
   output logic [DATA_W-1:0]   douta,
   output logic                vala,
   input  logic                wrenb,
   input  logic                rdenb,
   input  logic [ADDR_W-1:0]   addrb,
   input  logic [DATA_W/8-1:0] beb,
   input  logic [DATA_W-1:0]   dinb,
   output logic [DATA_W-1:0]   doutb,
   output logic                valb,
   output logic                collision
);
   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we, ina, inb, we_a, we_b, rd_a, rd_b, hit, wa_en, vq_a, vq_b;
   logic [ADDR_W-1:0] clr_addr, wa_addr;
   logic [BE_W-1:0]   wa_be;
   logic [DATA_W-1:0] wa_din, old_a, old_b, fin_a, fin_b, nxt_a, nxt_b, dq_a, dq_b;

   function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w, input logic en,
                                                input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
      merge = w;
      for (int i = 0; i < BE_W; i++)
         if (en && be[i]) merge[8*i +: 8] = d[8*i +: 8];
   endfunction

   tdp_bram_init_fsm #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_init (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign ina   = {1'b0, addra} < LIMIT;
   assign inb   = {1'b0, addrb} < LIMIT;
   assign we_a  = ~init_busy & wrena & ina & |bea;
   assign we_b  = ~init_busy & wrenb & inb & |beb;
   assign rd_a  = ~init_busy & rdena;
   assign rd_b  = ~init_busy & rdenb;
   assign hit   = addra == addrb;
   assign old_a = ina ? mem[addra] : '0;
   assign old_b = inb ? mem[addrb] : '0;

   // Final stored word at each port's address: lower-priority port merged first, winner on top
   assign fin_a = PRIORITY == PRIO_A ? merge(merge(old_a, we_b & hit, beb, dinb), we_a, bea, dina)
                                     : merge(merge(old_a, we_a, bea, dina), we_b & hit, beb, dinb);
   assign fin_b = PRIORITY == PRIO_A ? merge(merge(old_b, we_b, beb, dinb), we_a & hit, bea, dina)
                                     : merge(merge(old_b, we_a & hit, bea, dina), we_b, beb, dinb);

   assign nxt_a = !ina ? '0 : (we_a && RD_MODE == WR_FIRST) ? fin_a : (we_a && RD_MODE == NO_CHANGE) ? dq_a : old_a;
   assign nxt_b = !inb ? '0 : (we_b && RD_MODE == WR_FIRST) ? fin_b : (we_b && RD_MODE == NO_CHANGE) ? dq_b : old_b;

   // The clear sweep borrows port A's write path
   assign wa_en   = init_busy ? clr_we : we_a;
   assign wa_addr = init_busy ? clr_addr : addra;
   assign wa_be   = init_busy ? '1 : bea;
   assign wa_din  = init_busy ? '0 : dina;

   // Later non-blocking write wins, so the priority port is written last
   always_ff @(posedge clk)
      for (int i = 0; i < BE_W; i++)
         if (PRIORITY == PRIO_A) begin
            if (we_b && beb[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
            if (wa_en && wa_be[i]) mem[wa_addr][8*i +: 8] <= wa_din[8*i +: 8];
         end else begin
            if (wa_en && wa_be[i]) mem[wa_addr][8*i +: 8] <= wa_din[8*i +: 8];
            if (we_b && beb[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
         end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dq_a      <= '0;
         dq_b      <= '0;
         vq_a      <= 1'b0;
         vq_b      <= 1'b0;
         collision <= 1'b0;
      end else begin
         vq_a      <= rd_a;
         vq_b      <= rd_b;
         collision <= we_a & we_b & hit & |(bea & beb);
         if (rd_a) dq_a <= nxt_a;
         if (rd_b) dq_b <= nxt_b;
      end

`ifdef TDP_BRAM_OUTREG_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         douta <= '0;
         doutb <= '0;
         vala  <= 1'b0;
         valb  <= 1'b0;
      end else begin
         douta <= dq_a;
         doutb <= dq_b;
         vala  <= vq_a;
         valb  <= vq_b;
      end
`else
   assign douta = dq_a;
   assign doutb = dq_b;
   assign vala  = vq_a;
   assign valb  = vq_b;
`endif
endmodule

// File: tb/tb_tdp_bram_ctrl.sv
// tb_tdp_bram_ctrl: three configurations (read-first/prio A, write-first/prio B/DEPTH 1000, no-change/prio A)
// driven with shared random and directed stimulus, checked against a word/byte-level memory model.
module tb_tdp_bram_ctrl;
   localparam int N = 3;
`ifdef TDP_BRAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrena, rdena, wrenb, rdenb;
   logic [9:0]  addra, addrb;
   logic [1:0]  bea, beb;
   logic [15:0] dina, dinb;
   logic [15:0] douta [N];
   logic [15:0] doutb [N];
   logic        vala [N];
   logic        valb [N];
   logic        coll [N];
   logic        busy [N];

   logic [15:0] m [N][1024];
   int          clr_left [N];
   logic [15:0] sa [N];
   logic [15:0] sb [N];
   logic        va [N];
   logic        vb [N];
   logic [15:0] xa [N];
   logic [15:0] xb [N];
   logic        xva [N];
   logic        xvb [N];
   logic        xc [N];
   logic        xbusy [N];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      tdp_bram_ctrl #(
         .DATA_W   (16),
         .ADDR_W   (10),
         .DEPTH    (g == 1 ? 1000 : 1024),
         .RD_MODE  (g),
         .PRIORITY (g == 1 ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .init_busy (busy[g]),
         .wrena     (wrena),
         .rdena     (rdena),
         .addra     (addra),
         .bea       (bea),
         .dina      (dina),
         .douta     (douta[g]),
         .vala      (vala[g]),
         .wrenb     (wrenb),
         .rdenb     (rdenb),
         .addrb     (addrb),
         .beb       (beb),
         .dinb      (dinb),
         .doutb     (doutb[g]),
         .valb      (valb[g]),
         .collision (coll[g])
      );
   end

   function automatic int depth_of(int k);
      return k == 1 ? 1000 : 1024;
   endfunction

   function automatic bit prio_b(int k);
      return k == 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      {wrena, rdena, wrenb, rdenb} = '0;
      addra = '0; addrb = '0; bea = '0; beb = '0; dina = '0; dinb = '0;
   endtask

   task automatic drive(input logic wa, input logic ra, input logic [9:0] aa, input logic [1:0] ba, input logic [15:0] da,
                        input logic wb, input logic rb, input logic [9:0] ab, input logic [1:0] bb, input logic [15:0] db);
      wrena = wa; rdena = ra; addra = aa; bea = ba; dina = da;
      wrenb = wb; rdenb = rb; addrb = ab; beb = bb; dinb = db;
   endtask

   function automatic logic [9:0] rnd_addr();
      int s;
      s = $urandom_range(0, 3);
      if (s == 0) return 10'($urandom_range(1000, 1023));
      if (s == 1) return 10'($urandom_range(0, 1023));
      return 10'($urandom_range(0, 7));
   endfunction

   task automatic rnd_in();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), 2'($urandom_range(0, 3)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), 2'($urandom_range(0, 3)), 16'($urandom));
   endtask

   // Word stored at addr once this cycle's writes land (byte-wise, priority port wins shared bytes)
   function automatic logic [15:0] after(int k, logic [9:0] addr, logic wa, logic wb);
      logic [15:0] w;
      logic ha, hb;
      w = m[k][addr];
      for (int i = 0; i < 2; i++) begin
         ha = wa && addra == addr && bea[i];
         hb = wb && addrb == addr && beb[i];
         if (ha && hb) w[8*i +: 8] = prio_b(k) ? dinb[8*i +: 8] : dina[8*i +: 8];
         else if (ha) w[8*i +: 8] = dina[8*i +: 8];
         else if (hb) w[8*i +: 8] = dinb[8*i +: 8];
      end
      return w;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < N; k++) begin
         for (int a = 0; a < 1024; a++) m[k][a] = '0;
         clr_left[k] = depth_of(k);
         sa[k] = '0; sb[k] = '0; va[k] = 1'b0; vb[k] = 1'b0;
         xa[k] = '0; xb[k] = '0; xva[k] = 1'b0; xvb[k] = 1'b0; xc[k] = 1'b0; xbusy[k] = 1'b1;
      end
   endtask

   task automatic model_edge();
      logic ia, ib, wa, wb;
      logic [15:0] fa, fb, na, nb;
      for (int k = 0; k < N; k++) begin
`ifdef TDP_BRAM_OUTREG_EN
         xa[k] = sa[k]; xb[k] = sb[k]; xva[k] = va[k]; xvb[k] = vb[k];
`endif
         xc[k] = 1'b0;
         if (clr_left[k] > 0) begin
            clr_left[k]--;
            va[k] = 1'b0;
            vb[k] = 1'b0;
         end else begin
            ia = int'(addra) < depth_of(k);
            ib = int'(addrb) < depth_of(k);
            wa = wrena && ia && bea != 0;
            wb = wrenb && ib && beb != 0;
            fa = after(k, addra, wa, wb);
            fb = after(k, addrb, wa, wb);
            na = !ia ? 16'h0 : !wa ? m[k][addra] : k == 1 ? fa : k == 2 ? sa[k] : m[k][addra];
            nb = !ib ? 16'h0 : !wb ? m[k][addrb] : k == 1 ? fb : k == 2 ? sb[k] : m[k][addrb];
            if (rdena) sa[k] = na;
            if (rdenb) sb[k] = nb;
            va[k] = rdena;
            vb[k] = rdenb;
            xc[k] = wa && wb && addra == addrb && (bea & beb) != 0;
            if (wa) m[k][addra] = fa;
            if (wb) m[k][addrb] = fb;
         end
`ifndef TDP_BRAM_OUTREG_EN
         xa[k] = sa[k]; xb[k] = sb[k]; xva[k] = va[k]; xvb[k] = vb[k];
`endif
         xbusy[k] = clr_left[k] > 0;
      end
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s u%0d douta", ph, k), 32'(douta[k]), 32'(xa[k]));
         chk($sformatf("%s u%0d doutb", ph, k), 32'(doutb[k]), 32'(xb[k]));
         chk($sformatf("%s u%0d vala", ph, k), 32'(vala[k]), 32'(xva[k]));
         chk($sformatf("%s u%0d valb", ph, k), 32'(valb[k]), 32'(xvb[k]));
         chk($sformatf("%s u%0d collision", ph, k), 32'(coll[k]), 32'(xc[k]));
         chk($sformatf("%s u%0d init_busy", ph, k), 32'(busy[k]), 32'(xbusy[k]));
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all("cyc");
   endtask

   task automatic lat_wait();
      idle();
      repeat (LAT - 1) step();
   endtask

   task automatic clear_phase(input bit rnd);
      int cnt [N];
      for (int k = 0; k < N; k++) cnt[k] = 0;
      for (int c = 0; c < 1100; c++) begin
         if (!(busy[0] | busy[1] | busy[2])) break;
         if (rnd) rnd_in();
         else idle();
         for (int k = 0; k < N; k++) if (busy[k]) cnt[k]++;
         step();
      end
      idle();
      for (int k = 0; k < N; k++) chk($sformatf("clear length u%0d", k), 32'(cnt[k]), 32'(depth_of(k)));
   endtask

   task automatic async_reset(input string ph);
      #2 rst = 1'b1;
      reset_model();
      #1 check_all(ph);
      #10 rst = 1'b0;
   endtask

   initial begin
      idle();
      #1 rst = 1'b1;
      reset_model();
      #1 check_all("reset");
      #10 rst = 1'b0;
      clear_phase(1'b0);

      drive(0, 1, 10'd5, 2'b00, 16'h0, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      lat_wait();
      for (int k = 0; k < N; k++) begin
         chk($sformatf("post-clear u%0d douta", k), 32'(douta[k]), 32'h0000);
         chk($sformatf("post-clear u%0d vala", k), 32'(vala[k]), 32'h1);
      end

      drive(1, 0, 10'd1, 2'b11, 16'hABCD, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      drive(1, 0, 10'd1, 2'b01, 16'hFFFF, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      drive(0, 0, 10'd0, 2'b00, 16'h0, 0, 1, 10'd1, 2'b00, 16'h0);
      step();
      lat_wait();
      for (int k = 0; k < N; k++) chk($sformatf("byte-enable u%0d doutb", k), 32'(doutb[k]), 32'hABFF);

      drive(1, 0, 10'd5, 2'b11, 16'h0066, 1, 0, 10'd5, 2'b11, 16'h0077);
      step();
      for (int k = 0; k < N; k++) chk($sformatf("ww collision u%0d", k), 32'(coll[k]), 32'h1);
      idle();
      step();
      for (int k = 0; k < N; k++) chk($sformatf("collision drop u%0d", k), 32'(coll[k]), 32'h0);
      drive(0, 1, 10'd5, 2'b00, 16'h0, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      lat_wait();
      for (int k = 0; k < N; k++)
         chk($sformatf("ww winner u%0d", k), 32'(douta[k]), prio_b(k) ? 32'h0077 : 32'h0066);

      drive(1, 0, 10'd6, 2'b11, 16'h1111, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      drive(1, 1, 10'd6, 2'b11, 16'h2222, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      lat_wait();
      chk("rd-mode read-first u0", 32'(douta[0]), 32'h1111);
      chk("rd-mode write-first u1", 32'(douta[1]), 32'h2222);
      chk("rd-mode no-change u2", 32'(douta[2]), 32'h0066);
      chk("rd-mode no-change u2 vala", 32'(vala[2]), 32'h1);

      drive(1, 0, 10'd7, 2'b11, 16'hAAAA, 0, 0, 10'd0, 2'b00, 16'h0);
      step();
      drive(1, 0, 10'd7, 2'b11, 16'h5555, 0, 1, 10'd7, 2'b00, 16'h0);
      step();
      for (int k = 0; k < N; k++) chk($sformatf("cross-port no collision u%0d", k), 32'(coll[k]), 32'h0);
      lat_wait();
      for (int k = 0; k < N; k++) chk($sformatf("cross-port old u%0d", k), 32'(doutb[k]), 32'hAAAA);
      drive(0, 0, 10'd0, 2'b00, 16'h0, 0, 1, 10'd7, 2'b00, 16'h0);
      step();
      lat_wait();
      for (int k = 0; k < N; k++) chk($sformatf("cross-port new u%0d", k), 32'(doutb[k]), 32'h5555);

      repeat (3000) begin
         rnd_in();
         step();
      end

      drive(0, 1, 10'd6, 2'b00, 16'h0, 0, 1, 10'd7, 2'b00, 16'h0);
      step();
      async_reset("reset in ready");
      clear_phase(1'b1);

      repeat (300) step();
      async_reset("reset mid-clear");
      clear_phase(1'b0);

      repeat (500) begin
         rnd_in();
         step();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
